// File: rtl/dmem_store_unit.sv
// dmem_store_unit: buffers committed stores, lane-aligns them and drives the dmem write port
module dmem_store_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        st_valid_i,
    output logic        st_ready_o,
    input  logic        squash_i,
    input  logic [63:0] st_addr_i,
    input  logic [63:0] st_data_i,
    input  logic [3:0]  st_width_1h_i,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    output logic [7:0]  dmem_be_o,
    output logic        err_o,
    output logic [63:0] err_addr_o,
    output logic        empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [60:0]   addr_mem [DEPTH];
    logic [63:0]   data_mem [DEPTH];
    logic [7:0]    be_mem   [DEPTH];
    logic [2:0]    k;
    logic          accept, legal, push, pop;
    logic [63:0]   lane_data;
    logic [7:0]    lane_be;
    logic          err_q;
    logic [63:0]   err_addr_q;

    assign st_ready_o   = count != FULL;
    assign empty_o      = count == '0;
    assign dmem_req_o   = ~empty_o;
    assign dmem_we_o    = dmem_req_o;
    assign dmem_addr_o  = dmem_req_o ? {addr_mem[rd_ptr], 3'b000} : '0;
    assign dmem_wdata_o = dmem_req_o ? data_mem[rd_ptr] : '0;
    assign dmem_be_o    = dmem_req_o ? be_mem[rd_ptr] : '0;
    assign err_o        = err_q;
    assign err_addr_o   = err_addr_q;

    // Legality check and lane placement of the incoming store
    always_comb begin
        k         = st_addr_i[2:0];
        accept    = st_valid_i & st_ready_o & ~squash_i;
        legal     = (st_width_1h_i == 4'b0001) |
                    ((st_width_1h_i == 4'b0010) & ~k[0]) |
                    ((st_width_1h_i == 4'b0100) & (k[1:0] == 2'b00)) |
                    ((st_width_1h_i == 4'b1000) & (k == 3'b000));
        lane_data = st_width_1h_i[0] ? {8{st_data_i[7:0]}} :
                    st_width_1h_i[1] ? {4{st_data_i[15:0]}} :
                    st_width_1h_i[2] ? {2{st_data_i[31:0]}} : st_data_i;
        lane_be   = st_width_1h_i[0] ? (8'h01 << k) :
                    st_width_1h_i[1] ? (8'h03 << k) :
                    st_width_1h_i[2] ? (8'h0F << k) : 8'hFF;
        push      = accept & legal;
        pop       = dmem_req_o & dmem_gnt_i;
    end

    // Pointers, occupancy and the discarded-store error report
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            err_q <= accept & ~legal;
            if (accept & ~legal) err_addr_q <= st_addr_i;
        end
    end

    // Entry storage; outputs are masked while empty so it needs no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr] <= st_addr_i[63:3];
            data_mem[wr_ptr] <= lane_data;
            be_mem[wr_ptr]   <= lane_be;
        end
    end
endmodule

// File: tb/tb_dmem_store_unit.sv
// tb_dmem_store_unit: scoreboard bench with a byte-lane reference model
module tb_dmem_store_unit;
    localparam int DEPTH = 2;

    logic        clk = 0, rst = 1;
    logic        st_valid = 0, squash = 0, dmem_gnt = 0;
    logic [63:0] st_addr = 0, st_data = 0;
    logic [3:0]  st_width = 0;
    logic        st_ready, dmem_req, dmem_we, err, empty;
    logic [63:0] dmem_addr, dmem_wdata, err_addr;
    logic [7:0]  dmem_be;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
    } st_t;

    st_t         exp_q[$];
    logic [63:0] err_q[$];
    logic [63:0] last_err = 0;
    bit          ready_exp = 1;
    int          n_chk = 0, n_pass = 0;

    dmem_store_unit #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .st_valid_i(st_valid), .st_ready_o(st_ready), .squash_i(squash),
        .st_addr_i(st_addr), .st_data_i(st_data), .st_width_1h_i(st_width),
        .dmem_req_o(dmem_req), .dmem_gnt_i(dmem_gnt), .dmem_we_o(dmem_we),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_be_o(dmem_be),
        .err_o(err), .err_addr_o(err_addr), .empty_o(empty)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    // Reference: store size in bytes, natural alignment, byte lane i gets data byte i mod size
    function automatic void model_accept(input logic [63:0] a, input logic [63:0] d, input logic [3:0] w);
        int sz;
        int k;
        st_t e;
        sz = (w == 4'd1) ? 1 : (w == 4'd2) ? 2 : (w == 4'd4) ? 4 : (w == 4'd8) ? 8 : 0;
        k = int'(a % 8);
        if (sz == 0 || (a % sz) != 0) begin
            err_q.push_back(a);
            last_err = a;
            return;
        end
        e.addr = a - (a % 8);
        for (int i = 0; i < 8; i++) begin
            e.be[i] = (i >= k) && (i < k + sz);
            e.wdata[8*i +: 8] = d[8*(i % sz) +: 8];
        end
        exp_q.push_back(e);
    endfunction

    task automatic cyc(input logic v, input logic [63:0] a, input logic [63:0] d,
                       input logic [3:0] w, input logic sq, input logic g);
        st_valid = v; st_addr = a; st_data = d; st_width = w; squash = sq; dmem_gnt = g;
        @(posedge clk);
        if (v && !sq && ready_exp) model_accept(a, d, w);
        #1;
    endtask

    task automatic idle(input int n, input logic g);
        repeat (n) cyc(0, 0, 0, 0, 0, g);
    endtask

    // Monitor: compares every cycle against the model and pops on each handshake
    logic        stall_prev = 0;
    logic [63:0] p_addr, p_wdata;
    logic [7:0]  p_be;
    always @(negedge clk) begin
        st_t e;
        bit  rdy;
        rdy = exp_q.size() != DEPTH;
        chk("ready", 64'(st_ready), 64'(rdy));
        chk("empty", 64'(empty), 64'(exp_q.size() == 0));
        chk("req", 64'(dmem_req), 64'(exp_q.size() != 0));
        chk("we", 64'(dmem_we), 64'(dmem_req));
        chk("err", 64'(err), 64'(err_q.size() != 0));
        if (err_q.size() != 0) void'(err_q.pop_front());
        chk("err_addr", err_addr, last_err);
        if (stall_prev && !rst) begin
            chk("stall_addr", dmem_addr, p_addr);
            chk("stall_wdata", dmem_wdata, p_wdata);
            chk("stall_be", 64'(dmem_be), 64'(p_be));
        end
        if (dmem_req && dmem_gnt) begin
            if (exp_q.size() == 0) chk("spurious_issue", 64'(dmem_req), 64'(0));
            else begin
                e = exp_q.pop_front();
                chk("addr", dmem_addr, e.addr);
                chk("wdata", dmem_wdata, e.wdata);
                chk("be", 64'(dmem_be), 64'(e.be));
            end
        end
        stall_prev = dmem_req && !dmem_gnt && !rst;
        p_addr = dmem_addr; p_wdata = dmem_wdata; p_be = dmem_be;
        ready_exp = rdy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a;
        logic [3:0]  w;
        int          r;
        @(posedge clk); #1;
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_be", 64'(dmem_be), 0);
        @(posedge clk); #1;
        rst = 0;
        // byte store, back-to-back grant
        cyc(1, 64'h1005, 64'hAB, 4'b0001, 0, 1);
        idle(2, 1);
        // half then word with stalled grant
        cyc(1, 64'h2006, 64'h1234, 4'b0010, 0, 0);
        cyc(1, 64'h2004, 64'hDEADBEEF, 4'b0100, 0, 0);
        idle(3, 0);
        chk("stall_be_c0", 64'(dmem_be), 64'hC0);
        idle(3, 1);
        // misaligned word
        cyc(1, 64'h3002, 64'h55, 4'b0100, 0, 1);
        idle(2, 1);
        // squashed double, then non-one-hot width
        cyc(1, 64'h4000, 64'h1122334455667788, 4'b1000, 1, 1);
        cyc(1, 64'h4008, 64'h99, 4'b0011, 0, 1);
        idle(2, 1);
        // full buffer streaming with grant always high
        cyc(1, 64'h5000, 64'h01, 4'b0001, 0, 0);
        cyc(1, 64'h5001, 64'h02, 4'b0001, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, 64'h5100 + 64'(i), 64'(i + 16), 4'b0001, 0, 1);
        idle(3, 1);
        // reset while stalled with two entries
        cyc(1, 64'h6000, 64'hAAAA, 4'b0010, 0, 0);
        cyc(1, 64'h6008, 64'hBBBB, 4'b0010, 0, 0);
        idle(1, 0);
        rst = 1; st_valid = 0; dmem_gnt = 0;
        exp_q.delete(); err_q.delete(); last_err = 0;
        #1;
        chk("rst_req_drop", 64'(dmem_req), 0);
        chk("rst_empty", 64'(empty), 1);
        @(posedge clk); #1;
        rst = 0;
        idle(4, 1);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            w = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom);
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
            cyc(1'($urandom_range(0, 3) != 0), a, {$urandom, $urandom}, w,
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1, 1);
        idle(2, 1);
        chk("drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
